// File: rtl/memory_ctrl_pkg.sv
// Shared definitions for the memory controller: FSM state encoding and
// default geometry.
package memory_ctrl_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 9;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_ACC = 2'd1,
        WR_ACC = 2'd2,
        FINISH = 2'd3
    } state_t;

endpackage

// File: rtl/memory_ctrl_ram_sp.sv
// Single-port RAM: synchronous write, registered read, zero-initialised
// contents.
module ram_sp
    import memory_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W] = '{default: '0};

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/memory_ctrl.sv
// Memory controller: accepts one read or write from the control unit,
// sequences it against ram_sp and reports done/busy/err.
module memory_ctrl
    import memory_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] Mdatain,
    output logic              done,
    output logic              busy,
    output logic              err
);

    state_t            state, state_nxt;
    logic              acc_ph;
    logic              accept_rd, accept_wr;
    logic              ram_we;
    logic              err_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q, mdata_q, ram_q;

    always_comb begin
        state_nxt = state;
        accept_rd = 1'b0;
        accept_wr = 1'b0;
        case (state)
            IDLE: begin
                accept_rd = read & ~write;
                accept_wr = write & ~read;
                if (accept_rd)      state_nxt = RD_ACC;
                else if (accept_wr) state_nxt = WR_ACC;
            end
            RD_ACC:  if (acc_ph) state_nxt = FINISH;
            WR_ACC:  if (acc_ph) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Access states last two cycles (acc_ph 0 then 1) to cover the RAM's
    // registered read; a clr in the final write cycle must still block the write.
    assign ram_we = (state == WR_ACC) & acc_ph & ~clr;

    always_ff @(posedge clk) begin
        if (clr) begin
            state   <= IDLE;
            acc_ph  <= 1'b0;
            err_q   <= 1'b0;
            mdata_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state  <= state_nxt;
            acc_ph <= ((state == RD_ACC) || (state == WR_ACC)) && !acc_ph;
            err_q  <= (state == IDLE) && read && write;
            if (accept_rd || accept_wr) addr_q <= address;
            if (accept_wr)              data_q <= data_in;
            if ((state == RD_ACC) && acc_ph) mdata_q <= ram_q;
        end
    end

    ram_sp #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (addr_q),
        .wdata (data_q),
        .rdata (ram_q)
    );

    assign Mdatain = mdata_q;
    assign done    = (state == FINISH);
    assign busy    = (state != IDLE);
    assign err     = err_q;

endmodule

// File: tb/tb_memory_ctrl.sv
// Scoreboard bench for memory_ctrl: expected read data is queued at issue
// and compared when done is seen; timing, err and abort behaviour checked.
module tb_memory_ctrl;

    localparam int DW = 32;
    localparam int AW = 9;

    logic          clk;
    logic          clr, read, write;
    logic [AW-1:0] address;
    logic [DW-1:0] data_in, Mdatain;
    logic          done, busy, err;

    memory_ctrl #(
        .DATA_W (DW),
        .ADDR_W (AW)
    ) dut (
        .clk     (clk),
        .clr     (clr),
        .read    (read),
        .write   (write),
        .address (address),
        .data_in (data_in),
        .Mdatain (Mdatain),
        .done    (done),
        .busy    (busy),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            vectors     = 0;
    int            miscompares = 0;
    logic [DW-1:0] model [0:(1<<AW)-1];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] last_rd;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // One request; samples 6 cycles at #1 after each rising edge.
    task automatic run_op(input logic rd, input logic wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input bit mid);
        int            busy_cnt, done_cnt, done_at, err_cnt;
        logic [DW-1:0] exp_v;
        bit            is_rd, is_wr;
        busy_cnt = 0; done_cnt = 0; done_at = 0; err_cnt = 0;
        is_rd = rd && !wr;
        is_wr = wr && !rd;
        @(negedge clk);
        read = rd; write = wr; address = a; data_in = d;
        if (is_rd) exp_q.push_back(model[a]);
        if (is_wr) model[a] = d;
        @(posedge clk); #1;
        read = 1'b0; write = 1'b0;
        address = ~a;
        data_in = $urandom;
        for (int c = 1; c <= 6; c++) begin
            if (mid && c == 1) begin address = a + 9'd1; write = 1'b1; end
            if (mid && c == 2) write = 1'b0;
            if (busy) busy_cnt++;
            if (err)  err_cnt++;
            if (done) begin
                done_cnt++;
                if (done_at == 0) done_at = c;
                if (is_rd && exp_q.size() > 0) begin
                    exp_v = exp_q.pop_front();
                    check("rd_data", Mdatain, exp_v);
                    last_rd = exp_v;
                end
            end
            if (!is_rd) check("mdat_hold", Mdatain, last_rd);
            @(posedge clk); #1;
        end
        exp_q.delete();
        check("done_cnt", DW'(done_cnt), (is_rd || is_wr) ? 1 : 0);
        check("done_at",  DW'(done_at),  (is_rd || is_wr) ? 3 : 0);
        check("busy_cnt", DW'(busy_cnt), (is_rd || is_wr) ? 3 : 0);
        check("err_cnt",  DW'(err_cnt),  (is_rd || is_wr) ? 0 : 1);
    endtask

    // Start a write, assert clr in WR_ACC cycle 'at' (1 or 2); RAM must stay intact.
    task automatic abort_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input int at);
        int done_cnt;
        done_cnt = 0;
        @(negedge clk);
        write = 1'b1; address = a; data_in = d;
        @(posedge clk); #1;
        write = 1'b0;
        for (int c = 1; c < at; c++) begin
            @(posedge clk); #1;
        end
        clr = 1'b1;
        @(posedge clk); #1;
        check("abort_mdat", Mdatain, '0);
        check("abort_done", DW'(done), 0);
        check("abort_busy", DW'(busy), 0);
        check("abort_err",  DW'(err),  0);
        clr = 1'b0;
        last_rd = '0;
        repeat (4) begin
            @(posedge clk); #1;
            if (done) done_cnt++;
        end
        check("abort_nodone", DW'(done_cnt), 0);
    endtask

    initial begin
        logic [AW-1:0] ra;
        logic [DW-1:0] rd_v;
        for (int i = 0; i < (1 << AW); i++) model[i] = '0;
        last_rd = '0;
        clr = 1'b1; read = 1'b1; write = 1'b0; address = 9'h005; data_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mdat", Mdatain, '0);
        check("rst_done", DW'(done), 0);
        check("rst_busy", DW'(busy), 0);
        check("rst_err",  DW'(err),  0);
        clr = 1'b0; read = 1'b0;

        run_op(1'b0, 1'b1, 9'h005, 32'hDEADBEEF, 1'b0);
        run_op(1'b1, 1'b0, 9'h005, '0, 1'b0);

        run_op(1'b1, 1'b1, 9'h010, 32'hA5A5A5A5, 1'b0);
        run_op(1'b1, 1'b0, 9'h010, '0, 1'b0);

        run_op(1'b0, 1'b1, 9'h1FF, 32'h12345678, 1'b0);
        run_op(1'b0, 1'b1, 9'h000, 32'h0000FFFF, 1'b0);
        run_op(1'b1, 1'b0, 9'h1FF, '0, 1'b0);
        run_op(1'b1, 1'b0, 9'h000, '0, 1'b0);

        run_op(1'b1, 1'b0, 9'h005, '0, 1'b1);
        run_op(1'b1, 1'b0, 9'h006, '0, 1'b0);

        abort_wr(9'h020, 32'hCAFEF00D, 1);
        run_op(1'b1, 1'b0, 9'h020, '0, 1'b0);
        abort_wr(9'h021, 32'hCAFEF00D, 2);
        run_op(1'b1, 1'b0, 9'h021, '0, 1'b0);

        run_op(1'b1, 1'b0, 9'h005, '0, 1'b0);
        run_op(1'b0, 1'b1, 9'h007, 32'h00000001, 1'b0);
        run_op(1'b1, 1'b0, 9'h007, '0, 1'b0);

        for (int i = 0; i < 12; i++) begin
            ra   = AW'($urandom_range(0, (1 << AW) - 1));
            rd_v = $urandom;
            if ($urandom_range(0, 1) == 1) run_op(1'b0, 1'b1, ra, rd_v, 1'b0);
            else                           run_op(1'b1, 1'b0, ra, '0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/memory_ctrl.md
MEMORY_CTRL -- requirements
Module: memory_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning word width.
REQ-002 The block SHALL have parameter ADDR_W, default 9, meaning word address width; depth = 2**ADDR_W = 512 words.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port clr  input  1  reset, synchronous, active-high.
REQ-005 Port read  input  1  read request from control unit.
REQ-006 Port write  input  1  write request from control unit.
REQ-007 Port address  input  ADDR_W  word address, driven from MAR low bits.
REQ-008 Port data_in  input  DATA_W  write data, driven from MDR Q.
REQ-009 Port Mdatain  output  DATA_W  registered read data; feeds MDR memory-side input.
REQ-010 Port done  output  1  one-cycle pulse on completion of an accepted read or write.
REQ-011 Port busy  output  1  high while a request is in flight; new requests ignored.
REQ-012 Port err  output  1  one-cycle pulse when read and write are sampled high together in IDLE.

Function
REQ-013 The FSM SHALL have states IDLE, RD_ACC, WR_ACC, FINISH.
REQ-014 In IDLE with read=1, write=0, the block SHALL latch address and go to RD_ACC.
REQ-015 In IDLE with write=1, read=0, the block SHALL latch address and data_in and go to WR_ACC.
REQ-016 In IDLE with read=1 and write=1, the block SHALL stay in IDLE, perform no access, and pulse err for one cycle.
REQ-017 In RD_ACC, the RAM word at the latched address SHALL be read; Mdatain SHALL be loaded with it at the end of RD_ACC; go to FINISH.
REQ-018 In WR_ACC, the latched data SHALL be written to the latched address at the end of WR_ACC; go to FINISH.
REQ-019 In FINISH, done SHALL be 1 for exactly that cycle; next state is IDLE.
REQ-020 Latency: request sampled at edge N; Mdatain valid and done high in the cycle after edge N+2; next request accepted at edge N+3.
REQ-021 busy SHALL be 1 in RD_ACC, WR_ACC, FINISH and 0 in IDLE.
REQ-022 read/write while busy=1 SHALL be ignored, with no queuing and no err.
REQ-023 Mdatain SHALL hold its last read value through writes, idle cycles, and ignored requests.
REQ-024 Address and data_in changes after acceptance SHALL NOT affect the in-flight access.
REQ-025 Address is a word index with no wrap or overflow; all 2**ADDR_W values are valid.
REQ-026 A read of a never-written word SHALL return 0; RAM is initialised to 0 at elaboration.

Reset
REQ-027 With clr=1 at a rising edge: state -> IDLE; Mdatain=0, done=0, busy=0, err=0 after that edge.
REQ-028 clr SHALL take priority over read and write in the same cycle.
REQ-029 clr mid-operation SHALL abort the access; a write aborted in WR_ACC SHALL NOT modify RAM, and no done is issued.
REQ-030 clr SHALL NOT clear RAM contents.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding (IDLE, RD_ACC, WR_ACC, FINISH) and the DATA_W/ADDR_W defaults.
REQ-032 Storage SHALL be one sub-module, ram_sp (single-port, synchronous write, registered read, DATA_W x 2**ADDR_W); memory_ctrl holds the FSM and latches.

Verification
REQ-033 Write 0xDEADBEEF to addr 0x005, then read 0x005 -> done at cycle 3 of each op; Mdatain=0xDEADBEEF, busy high for 3 cycles.
REQ-034 Read and write both high in IDLE with addr 0x010 -> err pulse of 1 cycle, busy stays 0, RAM[0x010] unchanged (reads 0).
REQ-035 Write 0x12345678 to 0x1FF, then 0x0000FFFF to 0x000, read both -> 0x12345678 and 0x0000FFFF, no aliasing.
REQ-036 Issue a read to 0x005; change address to 0x006 and pulse write during RD_ACC -> returns 0xDEADBEEF, write ignored, RAM[0x006]=0.
REQ-037 Start a write of 0xCAFEF00D to 0x020; assert clr during WR_ACC -> outputs 0, no done, later read of 0x020 returns 0.
REQ-038 Read 0x005 (0xDEADBEEF), then write 0x1 to 0x007 -> Mdatain stays 0xDEADBEEF throughout the write.
